// File: rtl/tau_div_sched_if.sv
// tau_div_sched_if: request, divider and response bundle for tau_div_sched
//   req_vld/req_rI/req_rE/req_rdy : per-requester operands and one-hot accept
//   div_start/div_dividend/div_divisor/div_res_rdy/div_merchant : shared divider
//   rsp_vld/rsp_id/rsp_tau/rsp_err/rsp_rdy : tagged result channel
//   busy : scheduler is not idle
// slave is the scheduler side, master the environment side.
interface tau_div_sched_if #(
    parameter int NREQ = 4,
    parameter int N    = 21,
    parameter int M    = 13,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]   req_vld;
    logic [NREQ*M-1:0] req_rI;
    logic [NREQ*M-1:0] req_rE;
    logic [NREQ-1:0]   req_rdy;
    logic              div_start;
    logic [N-1:0]      div_dividend;
    logic [M-1:0]      div_divisor;
    logic              div_res_rdy;
    logic [N-1:0]      div_merchant;
    logic              rsp_vld;
    logic [IDW-1:0]    rsp_id;
    logic [7:0]        rsp_tau;
    logic              rsp_err;
    logic              rsp_rdy;
    logic              busy;

    modport slave (
        input  req_vld, req_rI, req_rE, div_res_rdy, div_merchant, rsp_rdy,
        output req_rdy, div_start, div_dividend, div_divisor,
               rsp_vld, rsp_id, rsp_tau, rsp_err, busy
    );

    modport master (
        output req_vld, req_rI, req_rE, div_res_rdy, div_merchant, rsp_rdy,
        input  req_rdy, div_start, div_dividend, div_divisor,
               rsp_vld, rsp_id, rsp_tau, rsp_err, busy
    );
endinterface

// File: rtl/tau_div_sched.sv
// tau_div_sched: round-robin scheduler sharing one iterative tau divider
//   clk  : rising-edge clock
//   rstn : asynchronous active-low reset
//   bus  : tau_div_sched_if.slave (requests, divider link, response, busy)
// Optional macro TAU_DIV_ZERO_CHK_EN: rE==0 is answered directly with
// tau=8'hFF and rsp_err=1 without using the divider; otherwise rsp_err is 0.
module tau_div_sched #(
    parameter int NREQ = 4,
    parameter int N    = 21,
    parameter int M    = 13,
    parameter int IDW  = 2
) (
    input  logic           clk,
    input  logic           rstn,
    tau_div_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d, id_q, id_d, rid_q, rid_d;
    logic [IDW-1:0] gnt, idx;
    logic           gnt_vld;
    logic [M-1:0]   ri_g, re_g;
    logic [N-1:0]   dvd_q, dvd_d;
    logic [M-1:0]   dvs_q, dvs_d;
    logic [7:0]     tau_q, tau_d;
`ifdef TAU_DIV_ZERO_CHK_EN
    logic           err_q, err_d;
`endif

    // Scan downward in offset so the closest requester at or after the pointer wins.
    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        idx     = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = IDW'((int'(ptr_q) + i) % NREQ);
            if (bus.req_vld[idx]) begin
                gnt     = idx;
                gnt_vld = 1'b1;
            end
        end
    end

    assign ri_g = bus.req_rI[gnt*M +: M];
    assign re_g = bus.req_rE[gnt*M +: M];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        rid_d   = rid_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        tau_d   = tau_q;
`ifdef TAU_DIV_ZERO_CHK_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: if (gnt_vld) begin
                dvd_d   = N'({ri_g, 8'b0});
                dvs_d   = re_g;
                id_d    = gnt;
                ptr_d   = IDW'((int'(gnt) + 1) % NREQ);
                state_d = ISSUE;
`ifdef TAU_DIV_ZERO_CHK_EN
                if (re_g == '0) begin
                    rid_d   = gnt;
                    tau_d   = 8'hFF;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
`endif
            end
            ISSUE: state_d = WAIT;
            WAIT: if (bus.div_res_rdy) begin
                rid_d   = id_q;
                tau_d   = bus.div_merchant[7:0];
`ifdef TAU_DIV_ZERO_CHK_EN
                err_d   = 1'b0;
`endif
                state_d = RESP;
            end
            RESP: if (bus.rsp_rdy) state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            rid_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            tau_q   <= '0;
`ifdef TAU_DIV_ZERO_CHK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            rid_q   <= rid_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            tau_q   <= tau_d;
`ifdef TAU_DIV_ZERO_CHK_EN
            err_q   <= err_d;
`endif
        end
    end

    // rstn gates the accept pulse so nothing is granted while held in reset.
    assign bus.req_rdy      = (rstn && state_q == IDLE && gnt_vld) ? NREQ'(1) << gnt : '0;
    assign bus.div_start    = state_q == ISSUE;
    assign bus.div_dividend = dvd_q;
    assign bus.div_divisor  = dvs_q;
    assign bus.rsp_vld      = state_q == RESP;
    assign bus.rsp_id       = rid_q;
    assign bus.rsp_tau      = tau_q;
    assign bus.busy         = state_q != IDLE;
`ifdef TAU_DIV_ZERO_CHK_EN
    assign bus.rsp_err      = err_q;
`else
    assign bus.rsp_err      = 1'b0;
`endif
endmodule

// File: tb/tb_tau_div_sched.sv
// tb_tau_div_sched: randomized and directed bench for tau_div_sched
module tb_tau_div_sched;
    localparam int NREQ = 4;
    localparam int N    = 21;
    localparam int M    = 13;
    localparam int IDW  = 2;
`ifdef TAU_DIV_ZERO_CHK_EN
    localparam bit ZCHK = 1'b1;
`else
    localparam bit ZCHK = 1'b0;
`endif

    logic clk, rstn, auto_rdy, man_rdy, auto_div;
    int   n_chk = 0, n_err = 0;
    int   gq[$];

    tau_div_sched_if #(.NREQ(NREQ), .N(N), .M(M), .IDW(IDW)) bus ();

    tau_div_sched #(.NREQ(NREQ), .N(N), .M(M), .IDW(IDW)) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    assign bus.div_res_rdy = auto_rdy | man_rdy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int k, input int ri, input int re);
        bus.req_rI[k*M +: M] = M'(ri);
        bus.req_rE[k*M +: M] = M'(re);
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (!bus.rsp_vld && n < 100) begin
            tick();
            n++;
        end
        chk("rsp_timeout", bus.rsp_vld, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 200) begin
            tick();
            n++;
        end
        chk("idle_timeout", bus.busy, 0);
    endtask

    task automatic do_reset();
        bus.req_vld = '0;
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        tick();
    endtask

    // Divider stand-in: random latency, true quotient, all ones for a zero divisor.
    initial begin
        logic [N-1:0] dvd;
        logic [M-1:0] dvs;
        int lat;
        bus.div_merchant = '0;
        auto_rdy = 1'b0;
        forever begin
            tick();
            if (auto_div && bus.div_start) begin
                dvd = bus.div_dividend;
                dvs = bus.div_divisor;
                lat = $urandom_range(1, 5);
                repeat (lat) tick();
                if (rstn) begin
                    bus.div_merchant = (dvs == '0) ? '1 : N'(dvd / N'(dvs));
                    auto_rdy = 1'b1;
                    tick();
                    auto_rdy = 1'b0;
                end
            end
        end
    end

    // Reference model: one operation in flight, round-robin pick, timing as cycle offsets.
    int  cyc = 0, ptr_m = 0, start_at = -1, rsp_from = -1;
    bit  busy_m = 0;
    int  exp_id, exp_dvd, exp_dvs, exp_tau, exp_err;
    always @(negedge clk) begin
        int g, ri, re, p;
        bit nb, ev;
        if (!rstn) begin
            busy_m = 0; ptr_m = 0; start_at = -1; rsp_from = -1;
        end else begin
            cyc++;
            chk("busy", bus.busy, busy_m);
            nb = busy_m;
            if (!busy_m) begin
                g = -1;
                for (int i = 0; i < NREQ; i++) begin
                    p = (ptr_m + i) % NREQ;
                    if (g < 0 && bus.req_vld[p]) g = p;
                end
                chk("grant", bus.req_rdy, g < 0 ? 0 : (1 << g));
                if (g >= 0) begin
                    ri = int'(bus.req_rI[g*M +: M]);
                    re = int'(bus.req_rE[g*M +: M]);
                    exp_id  = g;
                    exp_dvd = ri * 256;
                    exp_dvs = re;
                    exp_tau = (re == 0) ? 255 : ((ri * 256) / re) % 256;
                    exp_err = (ZCHK && re == 0) ? 1 : 0;
                    start_at = exp_err ? -1 : cyc + 1;
                    rsp_from = exp_err ? cyc + 1 : -1;
                    ptr_m = (g + 1) % NREQ;
                    nb = 1;
                    gq.push_back(g);
                end
            end else begin
                chk("grant_busy", bus.req_rdy, 0);
            end
            chk("start", bus.div_start, cyc == start_at);
            if (cyc == start_at) begin
                chk("dividend", bus.div_dividend, exp_dvd);
                chk("divisor", bus.div_divisor, exp_dvs);
            end
            if (start_at >= 0 && cyc > start_at && rsp_from < 0 && bus.div_res_rdy) rsp_from = cyc + 1;
            ev = rsp_from >= 0 && cyc >= rsp_from;
            chk("rsp_vld", bus.rsp_vld, ev);
            if (ev) begin
                chk("rsp_id", bus.rsp_id, exp_id);
                chk("rsp_tau", bus.rsp_tau, exp_tau);
                chk("rsp_err", bus.rsp_err, exp_err);
                if (bus.rsp_rdy) begin
                    nb = 0; start_at = -1; rsp_from = -1;
                end
            end
            busy_m = nb;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [NREQ-1:0] v, gp;
        int exp_order[9] = '{0, 1, 2, 3, 0, 2, 3, 0, 2};
        int n;
        rstn = 1'b0; auto_div = 1'b1; man_rdy = 1'b0;
        bus.req_vld = '0; bus.req_rI = '0; bus.req_rE = '0; bus.rsp_rdy = 1'b0;
        repeat (3) tick();
        chk("rst_busy", bus.busy, 0);
        chk("rst_rsp_vld", bus.rsp_vld, 0);
        chk("rst_start", bus.div_start, 0);
        chk("rst_dvd", bus.div_dividend, 0);
        chk("rst_tau", bus.rsp_tau, 0);
        rstn = 1'b1;
        tick();

        // single request: 1.0 / 2.0
        set_op(0, 16, 32);
        bus.rsp_rdy = 1'b1;
        bus.req_vld = 4'b0001;
        #1;
        chk("t1_rdy", bus.req_rdy, 1);
        tick();
        bus.req_vld = '0;
        chk("t1_start", bus.div_start, 1);
        chk("t1_dvd", bus.div_dividend, 4096);
        chk("t1_dvs", bus.div_divisor, 32);
        wait_rsp();
        chk("t1_id", bus.rsp_id, 0);
        chk("t1_tau", bus.rsp_tau, 8'h80);
        chk("t1_err", bus.rsp_err, 0);
        wait_idle();

        // round-robin from a fresh pointer
        do_reset();
        gq.delete();
        for (int k = 0; k < NREQ; k++) set_op(k, $urandom_range(0, 8191), $urandom_range(1, 8191));
        bus.req_vld = '1;
        n = 0;
        while (gq.size() < 5 && n < 500) begin tick(); n++; end
        bus.req_vld = 4'b1101;
        while (gq.size() < 9 && n < 1000) begin tick(); n++; end
        bus.req_vld = '0;
        wait_idle();
        for (int i = 0; i < 9; i++) chk("t2_order", i < gq.size() ? gq[i] : 99, exp_order[i]);

        // backpressure on the response
        set_op(0, 40, 24);
        for (int k = 1; k < NREQ; k++) set_op(k, 16, 16);
        bus.rsp_rdy = 1'b0;
        bus.req_vld = 4'b0001;
        tick();
        bus.req_vld = '0;
        wait_rsp();
        bus.req_vld = 4'b1110;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_vld", bus.rsp_vld, 1);
            chk("t3_tau", bus.rsp_tau, (40 * 256 / 24) % 256);
            chk("t3_rdy", bus.req_rdy, 0);
            chk("t3_start", bus.div_start, 0);
        end
        bus.rsp_rdy = 1'b1;
        tick();
        chk("t3_vld_drop", bus.rsp_vld, 0);
        chk("t3_no_start", bus.div_start, 0);
        tick();
        bus.req_vld = '0;
        chk("t3_start_after", bus.div_start, 1);
        wait_idle();

        // spurious result pulses in IDLE and ISSUE
        man_rdy = 1'b1;
        tick();
        man_rdy = 1'b0;
        chk("t4_idle_busy", bus.busy, 0);
        chk("t4_idle_vld", bus.rsp_vld, 0);
        set_op(3, 20, 48);
        bus.req_vld = 4'b1000;
        tick();
        bus.req_vld = '0;
        man_rdy = 1'b1;
        chk("t4_start", bus.div_start, 1);
        tick();
        man_rdy = 1'b0;
        chk("t4_wait_vld", bus.rsp_vld, 0);
        chk("t4_wait_busy", bus.busy, 1);
        wait_rsp();
        chk("t4_id", bus.rsp_id, 3);
        chk("t4_tau", bus.rsp_tau, 8'h6A);
        wait_idle();

        // divide by zero
        set_op(1, 100, 0);
        bus.req_vld = 4'b0010;
        tick();
        bus.req_vld = '0;
        chk("t5_start", bus.div_start, !ZCHK);
        if (!ZCHK) chk("t5_dvs", bus.div_divisor, 0);
        wait_rsp();
        chk("t5_tau", bus.rsp_tau, 8'hFF);
        chk("t5_err", bus.rsp_err, ZCHK);
        wait_idle();

        // reset while waiting on the divider
        auto_div = 1'b0;
        set_op(1, 32, 16);
        bus.req_vld = 4'b0010;
        tick();
        bus.req_vld = '0;
        tick();
        chk("t6_busy", bus.busy, 1);
        bus.req_vld = 4'b1010;
        rstn = 1'b0;
        #1;
        chk("t6_rdy0", bus.req_rdy, 0);
        chk("t6_busy0", bus.busy, 0);
        chk("t6_dvd0", bus.div_dividend, 0);
        chk("t6_dvs0", bus.div_divisor, 0);
        chk("t6_id0", bus.rsp_id, 0);
        chk("t6_tau0", bus.rsp_tau, 0);
        tick();
        tick();
        chk("t6_vld0", bus.rsp_vld, 0);
        auto_div = 1'b1;
        set_op(2, 64, 48);
        bus.req_vld = 4'b0100;
        rstn = 1'b1;
        #1;
        chk("t6_gnt", bus.req_rdy, 4);
        tick();
        bus.req_vld = '0;
        wait_rsp();
        chk("t6_id", bus.rsp_id, 2);
        chk("t6_tau", bus.rsp_tau, 8'h55);
        wait_idle();
        do_reset();
        bus.req_vld = 4'b1010;
        #1;
        chk("t6_ptr0", bus.req_rdy, 2);
        tick();
        bus.req_vld = '0;
        wait_rsp();
        wait_idle();

        // random traffic
        v = '0;
        gp = '0;
        for (int it = 0; it < 600; it++) begin
            tick();
            v &= ~gp;
            for (int k = 0; k < NREQ; k++) begin
                if (!v[k] && $urandom_range(0, 3) == 0) begin
                    set_op(k, $urandom_range(0, 8191), ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 8191));
                    v[k] = 1'b1;
                end else if (v[k] && $urandom_range(0, 15) == 0) begin
                    v[k] = 1'b0;
                end
            end
            bus.req_vld = v;
            bus.rsp_rdy = $urandom_range(0, 2) != 0;
            #1;
            gp = bus.req_rdy;
        end
        tick();
        bus.req_vld = '0;
        bus.rsp_rdy = 1'b1;
        wait_idle();
        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/tau_div_sched.md
Name: tau_div_sched

Overview:
Shares one iterative tau divider (quotient = (rI<<8)/rE, 8 fractional bits kept) between NREQ requesters.
- Arbitrates round-robin and issues one division at a time.
- Waits for the divider's result-ready, then returns tau[7:0] tagged with the requester ID over a valid/ready response channel.
- Sits between the per-channel rI/rE producers and the single divider instance.

Parameters:
NREQ, 4, number of requesters (2..8)
N, 21, divider dividend/quotient width
M, 13, rI/rE width (unsigned 9.4 fixed point)
IDW, 2, requester ID width (must equal clog2(NREQ))

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset; also drives the divider's reset
req_vld  in  NREQ  per-requester request valid
req_rI  in  NREQ*M  packed rI operands; requester k at [k*M +: M]
req_rE  in  NREQ*M  packed rE operands; same packing
req_rdy  out  NREQ  one-hot accept pulse to the granted requester
div_start  out  1  one-cycle start pulse to the divider (its data_rdy)
div_dividend  out  N  registered dividend
div_divisor  out  M  registered divisor
div_res_rdy  in  1  divider result-ready
div_merchant  in  N  divider quotient
rsp_vld  out  1  response valid
rsp_id  out  IDW  requester index of the response
rsp_tau  out  8  tau, 8 fractional bits
rsp_err  out  1  divide-by-zero flag (see Optional Feature)
rsp_rdy  in  1  consumer accepts the response
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, rstn=0): state=IDLE; RR pointer=0; all outputs 0, including req_rdy, div_start, div_dividend, div_divisor, rsp_*, and busy.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_vld is high, grant the first set bit searching from the pointer upward with wrap.
  - req_rdy[g]=1 combinationally in that cycle; it is asserted only in IDLE.
  - Register div_dividend = {rI_g,8'b0} truncated/zero-extended to N bits, div_divisor = rE_g, id = g.
  - Pointer <= (g+1) mod NREQ. Next state ISSUE.
  - With no request, stay in IDLE; the pointer does not move.
- ISSUE: div_start=1 for exactly this cycle; next state WAIT.
- WAIT:
  - div_res_rdy is sampled only here; pulses in any other state are ignored.
  - On div_res_rdy=1, capture rsp_tau=div_merchant[7:0], rsp_id=id, rsp_err=0; next state RESP.
  - No timeout.
- RESP:
  - rsp_vld=1; rsp_id, rsp_tau and rsp_err are held stable until rsp_rdy=1.
  - On rsp_rdy=1, go to IDLE. rsp_vld falls the next cycle.
  - No arbitration occurs in the handshake cycle.
- Latency: grant in cycle t, div_start at t+1, WAIT from t+2.
  - rsp_vld is high one cycle after the cycle in which div_res_rdy is sampled.
  - Best-case request-to-request spacing is divider latency + 4 cycles.
- Operands are captured at grant; later changes on req_rI/req_rE do not affect the operation in flight.
- Requesters must hold req_vld and operands stable until req_rdy.
- Requesters that drop req_vld before being granted are simply skipped.
- rstn low in any state aborts the operation, and the result is discarded.
  - After release the block starts in IDLE with pointer 0.
  - No response is ever produced for the aborted request.

Optional Feature:
Macro: TAU_DIV_ZERO_CHK_EN.
- Defined: at grant, if rE_g == 0, skip ISSUE and WAIT and go directly to RESP with rsp_tau=8'hFF and rsp_err=1. div_start is not pulsed for that request.
- Not defined: rE=0 is issued to the divider like any other value; rsp_err is tied to 0.

Test Plan:
1. Single request, req 0: rI=13'd16 (1.0), rE=13'd32 (2.0).
   - Required: div_start 1 cycle after req_rdy[0]; div_dividend=4096, div_divisor=32.
   - Divider model returns 128 -> rsp_vld with rsp_id=0, rsp_tau=8'h80, rsp_err=0.
2. Round-robin: all 4 req_vld held high, rsp_rdy=1.
   - Required: grant order 0,1,2,3,0.
   - Then drop req 1 and keep the others: order continues 2,3,0,2.
3. Backpressure: hold rsp_rdy=0 for 5 cycles in RESP with other req_vld high.
   - Required: rsp_vld and data stable, req_rdy all 0, no div_start until 1 cycle after rsp_rdy=1.
4. Spurious result: pulse div_res_rdy during IDLE and during ISSUE.
   - Required: no rsp_vld and no state change; the real pulse in WAIT completes normally.
5. Divide-by-zero, rE=0:
   - With TAU_DIV_ZERO_CHK_EN: rsp_tau=8'hFF, rsp_err=1, div_start never asserted.
   - Without the macro: div_start pulses with div_divisor=0.
6. Reset in WAIT: assert rstn=0 for 2 cycles.
   - Required: all outputs 0 immediately; no response for the aborted request.
   - After release, req 2 alone is granted first with pointer restarting at 0.
